// File: rtl/stopwatch_counter_multi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : stopwatch_pkg
// Brief    : Shared constants, two-digit BCD field type and digit helpers
//            for the multi-field stopwatch counter.
// Options  : none (STOPWATCH_DOWN_EN is consumed by the interface and top)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int BCD_W   = 4;
  localparam int SEC_MOD = 60;

  // One two-digit field: tens in the upper nibble, units in the lower.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } bcd2_t;

  // Saturate a digit at the given limit.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] v,
                                                   input logic [BCD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Binary value of a two-digit field (0..99).
  function automatic logic [6:0] bcd2_value(input bcd2_t f);
    return (7'(f.tens) * 7'd10) + 7'(f.units);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_counter_multi_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : stopwatch_counter_multi_if
// Brief    : Control / display bundle between the tick source, the user
//            controls and the stopwatch counter.
// Options  : STOPWATCH_DOWN_EN adds the dir_down_c count-direction signal.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface stopwatch_counter_multi_if #(
  parameter int N_FIELDS = 2,
  parameter int SEL_W    = $clog2(2*N_FIELDS)
);
`ifdef STOPWATCH_DOWN_EN
  logic                  dir_down_c;
`endif
  logic                  tick_c;
  logic                  pause_c;
  logic                  adj_c;
  logic [SEL_W-1:0]      sel_c;
  logic [3:0]            num_c;
  logic                  load_c;
  logic [8*N_FIELDS-1:0] digits;
  logic                  running;
  logic                  wrap;
  logic                  done;

  // Driver side: tick generator, buttons and display consumer.
  modport master (
`ifdef STOPWATCH_DOWN_EN
    output dir_down_c,
`endif
    output tick_c, pause_c, adj_c, sel_c, num_c, load_c,
    input  digits, running, wrap, done
  );

  // Counter side.
  modport slave (
`ifdef STOPWATCH_DOWN_EN
    input  dir_down_c,
`endif
    input  tick_c, pause_c, adj_c, sel_c, num_c, load_c,
    output digits, running, wrap, done
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_counter_multi_field.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : bcd_field_counter
// Brief    : One two-digit BCD field counting modulo MOD, with increment,
//            decrement, clamped single-digit load and carry/borrow outputs.
// Options  : none
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module bcd_field_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 60
) (
  input  wire logic             clk_c,
  input  wire logic             reset_c,
  input  wire logic             inc,
  input  wire logic             dec,
  input  wire logic             load,
  input  wire logic             ld_tens,
  input  wire logic [BCD_W-1:0] value,
  output bcd2_t                 digits,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  is_zero
);

  localparam logic [BCD_W-1:0] TENS_MAX     = BCD_W'((MOD - 1) / 10);
  localparam logic [BCD_W-1:0] UNITS_AT_MAX = BCD_W'((MOD - 1) % 10);
  // Mod-60 fields saturate a written tens digit at 5; other moduli rely on
  // the full-value check below.
  localparam logic [BCD_W-1:0] TENS_LIM     = (MOD == SEC_MOD) ? 4'd5 : 4'd9;
  localparam logic [6:0]       MOD_V        = 7'(MOD);

  bcd2_t digits_q;
  bcd2_t digits_d;
  bcd2_t loaded;
  logic  at_max;

  assign at_max     = (digits_q.tens == TENS_MAX) && (digits_q.units == UNITS_AT_MAX);
  assign is_zero    = (digits_q == '0);
  assign carry_out  = inc & ~load & at_max;
  assign borrow_out = dec & ~load & ~inc & is_zero;
  assign digits     = digits_q;

  // Value a load would produce: clamp the written digit, then the field.
  always_comb begin
    loaded = digits_q;
    if (ld_tens) begin
      loaded.tens = clamp_digit(value, TENS_LIM);
    end else begin
      loaded.units = clamp_digit(value, 4'd9);
    end
    if (bcd2_value(loaded) >= MOD_V) begin
      loaded = '{tens: TENS_MAX, units: UNITS_AT_MAX};
    end
  end

  // Next field value: load has priority over increment over decrement.
  always_comb begin
    digits_d = digits_q;
    if (load) begin
      digits_d = loaded;
    end else if (inc) begin
      if (at_max) begin
        digits_d = '0;
      end else if (digits_q.units == 4'd9) begin
        digits_d.units = 4'd0;
        digits_d.tens  = digits_q.tens + 4'd1;
      end else begin
        digits_d.units = digits_q.units + 4'd1;
      end
    end else if (dec) begin
      if (is_zero) begin
        digits_d = '{tens: TENS_MAX, units: UNITS_AT_MAX};
      end else if (digits_q.units == 4'd0) begin
        digits_d.units = 4'd9;
        digits_d.tens  = digits_q.tens - 4'd1;
      end else begin
        digits_d.units = digits_q.units - 4'd1;
      end
    end
  end

  // Field register.
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : stopwatch_counter_multi
// Brief    : N_FIELDS cascaded two-digit BCD stopwatch (SS, MM[, HH]) with
//            pause toggle, clamped per-digit adjust and a wrap pulse.
// Options  : STOPWATCH_DOWN_EN compiles in countdown (dir_down_c) and the
//            sticky done flag; without it done is tied low.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module stopwatch_counter_multi
  import stopwatch_pkg::*;
#(
  parameter int N_FIELDS = 2,
  parameter int TOP_MOD  = 60,
  parameter int SEL_W    = $clog2(2*N_FIELDS)
) (
  input wire logic clk_c,
  input wire logic reset_c,
  stopwatch_counter_multi_if.slave bus
);

  localparam int FS_W = SEL_W - 1;

  logic                paused_q, paused_d;
  logic                wrap_q, wrap_d;
  logic                running;
  logic                tick_ok;
  logic                sel_ok;
  logic                load_ok;
  logic                count_up;
  logic                count_dn;
  logic                all_zero;
  logic [N_FIELDS:0]   inc_chain;
  logic [N_FIELDS:0]   dec_chain;
  logic [N_FIELDS-1:0] zero_w;
  bcd2_t               field_w [N_FIELDS];
  logic                unused_top_borrow;

  // Pause is sampled before any same-cycle toggle; adjust always freezes.
  assign running  = ~paused_q & ~bus.adj_c;
  assign tick_ok  = bus.tick_c & running;
  assign sel_ok   = (32'(bus.sel_c) < 32'(2*N_FIELDS));
  assign load_ok  = bus.load_c & bus.adj_c & sel_ok;
  assign all_zero = &zero_w;

  assign inc_chain[0]      = count_up;
  assign dec_chain[0]      = count_dn;
  assign unused_top_borrow = dec_chain[N_FIELDS];

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
    localparam int FMOD = (i == N_FIELDS - 1) ? TOP_MOD : SEC_MOD;
    bcd_field_counter #(
      .MOD (FMOD)
    ) u_field (
      .clk_c      (clk_c),
      .reset_c    (reset_c),
      .inc        (inc_chain[i]),
      .dec        (dec_chain[i]),
      .load       (load_ok && (bus.sel_c[SEL_W-1:1] == FS_W'(i))),
      .ld_tens    (bus.sel_c[0]),
      .value      (bus.num_c),
      .digits     (field_w[i]),
      .carry_out  (inc_chain[i+1]),
      .borrow_out (dec_chain[i+1]),
      .is_zero    (zero_w[i])
    );
  end

  // Pack the field array onto the flat display bus.
  always_comb begin
    bus.digits = '0;
    for (int i = 0; i < N_FIELDS; i++) begin
      bus.digits[8*i +: 8] = field_w[i];
    end
  end

  // Pause toggle (ignored while adjusting) and the top-field wrap pulse.
  always_comb begin
    paused_d = paused_q ^ (bus.pause_c & ~bus.adj_c);
    wrap_d   = inc_chain[N_FIELDS];
  end

  // Control registers.
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      paused_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      paused_q <= paused_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.running = running;
  assign bus.wrap    = wrap_q;

`ifdef STOPWATCH_DOWN_EN
  logic done_q, done_d;

  // Direction split; a down tick at all-zero or after done is consumed.
  always_comb begin
    count_up = tick_ok & ~bus.dir_down_c;
    count_dn = tick_ok & bus.dir_down_c & ~done_q & ~all_zero;
    done_d   = done_q;
    if (load_ok) begin
      done_d = 1'b0;
    end else if (tick_ok && bus.dir_down_c && all_zero) begin
      done_d = 1'b1;
    end
  end

  // Sticky countdown-complete flag.
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign bus.done = done_q;
`else
  logic unused_all_zero;

  assign count_up        = tick_ok;
  assign count_dn        = 1'b0;
  assign unused_all_zero = all_zero;
  assign bus.done        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_stopwatch_counter_multi
// Brief    : Directed bench for an HH:MM:SS (TOP_MOD 24) and an MM:SS
//            instance of stopwatch_counter_multi.
// Options  : STOPWATCH_DOWN_EN enables the countdown steps.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_stopwatch_counter_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_counter_multi_if #(.N_FIELDS(3)) ifa ();
  stopwatch_counter_multi_if #(.N_FIELDS(2)) ifb ();

  stopwatch_counter_multi #(.N_FIELDS(3), .TOP_MOD(24)) dut_a (
    .clk_c   (clk),
    .reset_c (rst),
    .bus     (ifa.slave)
  );

  stopwatch_counter_multi #(.N_FIELDS(2), .TOP_MOD(60)) dut_b (
    .clk_c   (clk),
    .reset_c (rst),
    .bus     (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_ticks(input int n);
    repeat (n) begin
      ifa.tick_c = 1'b1;
      step();
      ifa.tick_c = 1'b0;
    end
  endtask

  task automatic a_load(input logic [2:0] sel, input logic [3:0] num);
    ifa.sel_c  = sel;
    ifa.num_c  = num;
    ifa.load_c = 1'b1;
    step();
    ifa.load_c = 1'b0;
  endtask

  task automatic b_load(input logic [1:0] sel, input logic [3:0] num);
    ifb.sel_c  = sel;
    ifb.num_c  = num;
    ifb.load_c = 1'b1;
    step();
    ifb.load_c = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.tick_c = 0; ifa.pause_c = 0; ifa.adj_c = 0; ifa.sel_c = 0; ifa.num_c = 0; ifa.load_c = 0;
    ifb.tick_c = 0; ifb.pause_c = 0; ifb.adj_c = 0; ifb.sel_c = 0; ifb.num_c = 0; ifb.load_c = 0;
`ifdef STOPWATCH_DOWN_EN
    ifa.dir_down_c = 0;
    ifb.dir_down_c = 0;
`endif
    #1 rst = 1'b1;
    #20;
    chk("rst_digits", 32'(ifa.digits), 32'h000000);
    chk("rst_wrap", 32'(ifa.wrap), 32'h0);
    chk("rst_done", 32'(ifa.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_running", 32'(ifa.running), 32'h1);

    // Plain up count.
    a_ticks(3);
    chk("up3", 32'(ifa.digits), 32'h000003);

    // Adjust: tens clamp, frozen count, resume.
    ifa.adj_c = 1'b1;
    #1;
    chk("adj_running", 32'(ifa.running), 32'h0);
    a_load(3'd1, 4'd8);
    chk("sec_tens_clamp", 32'(ifa.digits), 32'h000053);
    a_ticks(10);
    chk("adj_frozen", 32'(ifa.digits), 32'h000053);
    ifa.adj_c = 1'b0;
    #1;
    chk("adj_exit_running", 32'(ifa.running), 32'h1);
    a_ticks(1);
    chk("resume", 32'(ifa.digits), 32'h000054);

    // Units clamp, out-of-range select, load without adjust.
    ifa.adj_c = 1'b1;
    a_load(3'd0, 4'd15);
    chk("units_clamp", 32'(ifa.digits), 32'h000059);
    a_load(3'd6, 4'd1);
    chk("bad_sel", 32'(ifa.digits), 32'h000059);
    ifa.adj_c = 1'b0;
    a_load(3'd0, 4'd2);
    chk("load_no_adj", 32'(ifa.digits), 32'h000059);
    a_ticks(1);
    chk("sec_carry", 32'(ifa.digits), 32'h000100);

    // Pause with a same-cycle tick: that tick counts, the next does not.
    ifa.pause_c = 1'b1;
    ifa.tick_c  = 1'b1;
    step();
    ifa.pause_c = 1'b0;
    ifa.tick_c  = 1'b0;
    chk("pause_tick", 32'(ifa.digits), 32'h000101);
    chk("paused_running", 32'(ifa.running), 32'h0);
    a_ticks(1);
    chk("paused_hold", 32'(ifa.digits), 32'h000101);
    ifa.pause_c = 1'b1;
    step();
    ifa.pause_c = 1'b0;
    a_ticks(1);
    chk("unpause", 32'(ifa.digits), 32'h000102);

    // Paused state survives adjust; pause ignored while adjusting.
    ifa.pause_c = 1'b1;
    step();
    ifa.adj_c = 1'b1;
    step();
    ifa.pause_c = 1'b0;
    ifa.adj_c   = 1'b0;
    #1;
    chk("pause_kept", 32'(ifa.running), 32'h0);
    ifa.pause_c = 1'b1;
    step();
    ifa.pause_c = 1'b0;
    chk("pause_off", 32'(ifa.running), 32'h1);

    // Hours field (mod 24) clamping.
    ifa.adj_c = 1'b1;
    a_load(3'd5, 4'd2);
    chk("hr_tens", 32'(ifa.digits), 32'h200102);
    a_load(3'd4, 4'd9);
    chk("hr_clamp", 32'(ifa.digits), 32'h230102);
    a_load(3'd5, 4'd8);
    chk("hr_tens_big", 32'(ifa.digits), 32'h230102);
    a_load(3'd3, 4'd7);
    a_load(3'd2, 4'd9);
    a_load(3'd1, 4'd5);
    a_load(3'd0, 4'd9);
    chk("max_loaded", 32'(ifa.digits), 32'h235959);
    ifa.adj_c = 1'b0;
    a_ticks(1);
    chk("full_wrap", 32'(ifa.digits), 32'h000000);
    chk("wrap_pulse", 32'(ifa.wrap), 32'h1);
    step();
    chk("wrap_one_cycle", 32'(ifa.wrap), 32'h0);

    // Load and tick together while adjusting: load wins.
    ifa.adj_c  = 1'b1;
    ifa.tick_c = 1'b1;
    a_load(3'd0, 4'd4);
    ifa.tick_c = 1'b0;
    ifa.adj_c  = 1'b0;
    chk("load_beats_tick", 32'(ifa.digits), 32'h000004);

`ifdef STOPWATCH_DOWN_EN
    ifa.adj_c = 1'b1;
    a_load(3'd0, 4'd1);
    ifa.adj_c      = 1'b0;
    ifa.dir_down_c = 1'b1;
    a_ticks(1);
    chk("dn_to_zero", 32'(ifa.digits), 32'h000000);
    chk("dn_not_done", 32'(ifa.done), 32'h0);
    a_ticks(1);
    chk("dn_hold_zero", 32'(ifa.digits), 32'h000000);
    chk("dn_done", 32'(ifa.done), 32'h1);
    ifa.dir_down_c = 1'b0;
    a_ticks(1);
    chk("up_while_done", 32'(ifa.digits), 32'h000001);
    chk("done_sticky", 32'(ifa.done), 32'h1);
    ifa.dir_down_c = 1'b1;
    a_ticks(1);
    chk("dn_blocked", 32'(ifa.digits), 32'h000001);
    ifa.adj_c = 1'b1;
    a_load(3'd2, 4'd1);
    ifa.adj_c = 1'b0;
    chk("load_clr_done", 32'(ifa.done), 32'h0);
    a_ticks(2);
    chk("dn_borrow", 32'(ifa.digits), 32'h000059);
    ifa.dir_down_c = 1'b0;
`else
    a_ticks(1);
    chk("no_done", 32'(ifa.done), 32'h0);
`endif

    // Asynchronous reset between clock edges.
    a_ticks(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'(ifa.digits), 32'h000000);
    #2 rst = 1'b0;
    step();

    // MM:SS instance: top field mod 60, tens clamp, full wrap.
    ifb.adj_c = 1'b1;
    b_load(2'd0, 4'd9);
    b_load(2'd1, 4'd5);
    b_load(2'd2, 4'd9);
    b_load(2'd3, 4'd9);
    chk("b_loaded", 32'(ifb.digits), 32'h5959);
    ifb.adj_c  = 1'b0;
    ifb.tick_c = 1'b1;
    step();
    ifb.tick_c = 1'b0;
    chk("b_wrap_digits", 32'(ifb.digits), 32'h0000);
    chk("b_wrap_pulse", 32'(ifb.wrap), 32'h1);
    step();
    chk("b_wrap_clear", 32'(ifb.wrap), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_counter_multi.md
# stopwatch_counter_multi

Parametrised successor of the two-field MM:SS stopwatch counter. Holds N_FIELDS cascaded two-digit BCD fields (SS, MM, optionally HH), counts on an external one-second tick, and supports pause toggle, per-digit adjust with clamping, and a compile-time countdown mode with a done flag. Sits between the clock-divider tick generator and the seven-segment display multiplexer.

## Interface
- N_FIELDS, 2: number of two-digit fields; legal values 2 (MM:SS) or 3 (HH:MM:SS); field 0 = seconds.
- TOP_MOD, 60: modulus of the most-significant field; legal range 2..100 (e.g. 24 for hours); all lower fields are mod 60.
- SEL_W, $clog2(2*N_FIELDS): width of the digit selector.

- clk_c  in  1  system clock.
- reset_c  in  1  asynchronous, active-high reset.
- tick_c  in  1  one-cycle count-enable pulse (1 Hz).
- pause_c  in  1  one-cycle pulse; toggles run/pause.
- adj_c  in  1  level; adjust mode while high.
- sel_c  in  SEL_W  digit index, 0 = seconds units, 1 = seconds tens, 2 = minutes units, ...
- num_c  in  4  value to load.
- load_c  in  1  one-cycle pulse; writes num_c into digit sel_c while adj_c = 1.
- dir_down_c  in  1  count direction (present only with STOPWATCH_DOWN_EN).
- digits  out  8*N_FIELDS  BCD digits, digit i at [4i+3:4i].
- running  out  1  1 = counting enabled (not paused, not adjusting).
- wrap  out  1  one-cycle pulse when the count wraps from maximum to zero.
- done  out  1  sticky countdown-complete flag (tied 0 without the macro).

## Operation
- Reset: all digits 0, paused = 0, done = 0, wrap = 0; running = 1 once reset deasserts.
- Priority per cycle: reset > load > tick.
- Pause: pause_c toggles paused when adj_c = 0; ignored while adj_c = 1.
- running = ~paused & ~adj_c. The tick_c pulse only advances the count when running is high, evaluated before any same-cycle pause toggle.
- Up count, seconds field: units 9→0 with carry into tens; tens 5→0 with carry into the next field. Intermediate fields behave the same.
- Up count, top field: wraps from TOP_MOD−1 to 0. When every field is at its maximum, a tick clears all fields and pulses wrap.
- Adjust: entering adj_c = 1 freezes counting. The paused state is preserved and restored on exit.
  - load_c writes num_c into the selected digit.
  - A units digit greater than 9 is written as 9.
  - A tens digit of a mod-60 field greater than 5 is written as 5.
  - After the write, if the top field's value is ≥ TOP_MOD, that field is set to TOP_MOD−1.
  - A sel_c index beyond 2*N_FIELDS−1 ignores the load.
  - load_c while adj_c = 0 is ignored.
- Any load, or reset, clears done.

## Timing
- Digits, wrap and done are registered. They update on the clk_c edge that samples the qualifying tick_c or load_c, and are visible the next cycle.
- wrap is high for exactly one cycle.
- Deasserting adj_c resumes counting on the first tick_c after deassertion.
- tick_c and load_c in the same cycle while adj_c = 1: the load wins and the tick is lost.
- Reset asserted mid-count clears state asynchronously; it does not wait for a clock edge.

## Configuration
- STOPWATCH_DOWN_EN defined: dir_down_c port and done logic are compiled in.
  - With dir_down_c = 1, a tick decrements the count. Units 0→9 borrow, tens 0→5 borrow, top field 0→TOP_MOD−1.
  - At all-zero, the tick is consumed: the count holds at zero and done sets.
  - done stays set until a load or reset. While done = 1, down ticks have no effect.
  - Up counting while done = 1 proceeds normally and leaves done set.
- STOPWATCH_DOWN_EN undefined: up-count only, no dir_down_c port, done tied to 0.

## Structure
- Package stopwatch_pkg: BCD_W = 4, SEC_MOD = 60, the digit-clamp function, and the typedef for a two-digit BCD field.
- Sub-module bcd_field_counter: one two-digit field, parameter MOD.
  - Inputs: inc, dec, load, digit select, value.
  - Outputs: digits, carry_out (on max→0), borrow_out (on 0→max), is_zero.
- The top level instantiates N_FIELDS of these in a carry/borrow chain and owns the pause, adjust, wrap and done logic.

## Test plan
- N_FIELDS=2, state 59:59, tick_c → 00:00 and wrap pulses one cycle.
- N_FIELDS=3, TOP_MOD=24, state 23:59:59, tick_c → 00:00:00 and wrap pulses.
- adj_c=1, sel_c=1, num_c=8, load_c → seconds tens = 5. Then 10 ticks → count unchanged. Then adj_c=0 → counting resumes.
- pause_c together with tick_c while running → that tick counts; the next tick is ignored; a second pause_c resumes counting.
- TOP_MOD=24, load hours tens = 2, then hours units = 9 → hours = 23.
- STOPWATCH_DOWN_EN, dir_down_c=1, state 00:01, two ticks → 00:00 then done=1; a load clears done.
